wb_dma_arbiter: RTL and testbench

Bus arbiter for the processor board's 16-bit Wishbone bus. It shares the bus between the CPU (the default owner) and up to NDMA DMA masters, such as disk controllers. It drives the CPU's grant input (`cpu_gnt_o`, which feeds the CPU's `wbm_gnt_i`) and muxes the winning master onto the shared bus. Ownership changes only at Wishbone cycle boundaries: DMA masters are picked round-robin, the CPU is guaranteed a bus window between DMA tenures, and a hold limit stops any one master from monopolising the bus.

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_dma_arbiter_rr_pick.sv | 39 +++
 rtl/wb_dma_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_wb_dma_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone CPU/DMA bus arbiter: FSM state
// encoding, bus field widths and a helper that sizes saturating counters.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,   // CPU owns the bus
        S_HAND = 2'd1,   // dead cycle before a DMA tenure
        S_DMA  = 2'd2,   // DMA master owns the bus
        S_RET  = 2'd3    // dead cycle before returning to the CPU
    } arb_state_e;

    localparam int BUS_W = 16;
    localparam int SEL_W = 2;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_dma_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requester found
// at or after rr_ptr+1 (modulo NDMA), plus a flag saying anyone asked.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NDMA  = 2,
    parameter int PTR_W = cnt_width(NDMA - 1)
) (
    input  logic [NDMA-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [PTR_W-1:0] win,
    output logic             valid
);

    // Candidate gi is the master sitting gi+1 places after the pointer.
    logic [PTR_W-1:0] cand_idx [NDMA];
    logic [NDMA-1:0]  cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NDMA; gi++) begin : g_cand
            assign cand_idx[gi] = PTR_W'((int'(rr_ptr) + 1 + gi) % NDMA);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate back so the nearest requester wins.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int i = NDMA - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                win   = cand_idx[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_dma_arbiter.sv
// Wishbone bus arbiter: shares the 16-bit bus between the CPU (default
// owner) and NDMA DMA masters. Ownership only changes between Wishbone
// cycles, with a dead cycle on each hand-over, a guaranteed CPU window
// between DMA tenures and an optional cap on DMA tenure length.
module wb_dma_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NDMA     = 2,
    parameter int CPU_SLOT = 8,
    parameter int MAX_HOLD = 64
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    // CPU master
    input  logic                  cpu_cyc_i,
    input  logic                  cpu_stb_i,
    input  logic                  cpu_we_i,
    input  logic [SEL_W-1:0]      cpu_sel_i,
    input  logic [BUS_W-1:0]      cpu_adr_i,
    input  logic [BUS_W-1:0]      cpu_dat_i,
    output logic                  cpu_ack_o,
    output logic                  cpu_gnt_o,
    // DMA masters (packed, master i in slice i)
    input  logic [NDMA-1:0]       dma_req_i,
    output logic [NDMA-1:0]       dma_gnt_o,
    input  logic [NDMA-1:0]       dma_cyc_i,
    input  logic [NDMA-1:0]       dma_stb_i,
    input  logic [NDMA-1:0]       dma_we_i,
    input  logic [SEL_W*NDMA-1:0] dma_sel_i,
    input  logic [BUS_W*NDMA-1:0] dma_adr_i,
    input  logic [BUS_W*NDMA-1:0] dma_dat_i,
    output logic [NDMA-1:0]       dma_ack_o,
    // Shared bus
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [SEL_W-1:0]      wb_sel_o,
    output logic [BUS_W-1:0]      wb_adr_o,
    output logic [BUS_W-1:0]      wb_dat_o,
    input  logic                  wb_ack_i
);

    localparam int PTR_W  = cnt_width(NDMA - 1);
    localparam int SLOT_W = cnt_width(CPU_SLOT);
    localparam int HOLD_W = cnt_width(MAX_HOLD);

    localparam logic [PTR_W-1:0]  PTR_RST  = PTR_W'(NDMA - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(CPU_SLOT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e        state_q,   state_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic [NDMA-1:0]   dma_gnt_q, dma_gnt_d;
    logic [PTR_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [PTR_W-1:0]  win_q,     win_d;      // master chosen for the current/next tenure
    logic [SLOT_W-1:0] slot_q,    slot_d;     // CPU clocks since it got the bus back
    logic [HOLD_W-1:0] hold_q,    hold_d;     // clocks into the current DMA tenure

    logic [PTR_W-1:0]  pick_win;
    logic              pick_valid;
    logic              hold_expired;

    rr_pick #(
        .NDMA  (NDMA),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (dma_req_i),
        .rr_ptr (rr_ptr_q),
        .win    (pick_win),
        .valid  (pick_valid)
    );

    // Unpack the per-master buses so the mux can index them directly.
    logic [SEL_W-1:0] dma_sel_a [NDMA];
    logic [BUS_W-1:0] dma_adr_a [NDMA];
    logic [BUS_W-1:0] dma_dat_a [NDMA];

    genvar gi;
    generate
        for (gi = 0; gi < NDMA; gi++) begin : g_unpack
            assign dma_sel_a[gi] = dma_sel_i[SEL_W*gi +: SEL_W];
            assign dma_adr_a[gi] = dma_adr_i[BUS_W*gi +: BUS_W];
            assign dma_dat_a[gi] = dma_dat_i[BUS_W*gi +: BUS_W];
        end
    endgenerate

    assign hold_expired = (MAX_HOLD != 0) && (hold_q >= HOLD_MAX);

    // Next-state logic: ownership moves only when the current owner is between cycles.
    always_comb begin
        state_d   = state_q;
        cpu_gnt_d = cpu_gnt_q;
        dma_gnt_d = dma_gnt_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        slot_d    = slot_q;
        hold_d    = hold_q;
        case (state_q)
            S_CPU: begin
                if (slot_q != SLOT_MAX) begin
                    slot_d = slot_q + 1'b1;
                end
                if (pick_valid && (slot_q == SLOT_MAX) && !cpu_cyc_i) begin
                    state_d   = S_HAND;
                    cpu_gnt_d = 1'b0;
                    win_d     = pick_win;
                end
            end
            S_HAND: begin
                state_d          = S_DMA;
                dma_gnt_d        = '0;
                dma_gnt_d[win_q] = 1'b1;
                rr_ptr_d         = win_q;
                hold_d           = '0;
            end
            S_DMA: begin
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
                // A running cycle is never cut; release only once cyc is low.
                if (!dma_cyc_i[win_q] && (!dma_req_i[win_q] || hold_expired)) begin
                    state_d   = S_RET;
                    dma_gnt_d = '0;
                end
            end
            S_RET: begin
                state_d   = S_CPU;
                cpu_gnt_d = 1'b1;
                slot_d    = '0;
            end
            default: begin
                state_d = S_CPU;
            end
        endcase
    end

    // State and grant registers; reset drops any DMA grant at once.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= S_CPU;
            cpu_gnt_q <= 1'b1;
            dma_gnt_q <= '0;
            rr_ptr_q  <= PTR_RST;
            win_q     <= '0;
            slot_q    <= SLOT_MAX;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cpu_gnt_q <= cpu_gnt_d;
            dma_gnt_q <= dma_gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            slot_q    <= slot_d;
            hold_q    <= hold_d;
        end
    end

    assign cpu_gnt_o = cpu_gnt_q;
    assign dma_gnt_o = dma_gnt_q;

    // Bus mux and ack routing from the registered owner; dead cycles drive nothing.
    always_comb begin
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_sel_o  = '0;
        wb_adr_o  = '0;
        wb_dat_o  = '0;
        cpu_ack_o = 1'b0;
        dma_ack_o = '0;
        case (state_q)
            S_CPU: begin
                wb_cyc_o  = cpu_cyc_i;
                wb_stb_o  = cpu_stb_i;
                wb_we_o   = cpu_we_i;
                wb_sel_o  = cpu_sel_i;
                wb_adr_o  = cpu_adr_i;
                wb_dat_o  = cpu_dat_i;
                cpu_ack_o = wb_ack_i;
            end
            S_DMA: begin
                wb_cyc_o         = dma_cyc_i[win_q];
                wb_stb_o         = dma_stb_i[win_q];
                wb_we_o          = dma_we_i[win_q];
                wb_sel_o         = dma_sel_a[win_q];
                wb_adr_o         = dma_adr_a[win_q];
                wb_dat_o         = dma_dat_a[win_q];
                dma_ack_o[win_q] = wb_ack_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Self-checking bench for wb_dma_arbiter (NDMA=2, CPU_SLOT=8, MAX_HOLD=16):
// a vector table, hand-written multi-cycle sequences, and a randomized run
// compared against an ownership-level reference model.
module tb_wb_dma_arbiter;

    localparam int NDMA     = 2;
    localparam int CPU_SLOT = 8;
    localparam int MAX_HOLD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_cyc, cpu_stb, cpu_we;
    logic [1:0]  cpu_sel;
    logic [15:0] cpu_adr, cpu_dat;
    logic        cpu_ack, cpu_gnt;
    logic [1:0]  dma_req, dma_gnt, dma_cyc, dma_stb, dma_we, dma_ack;
    logic [3:0]  dma_sel;
    logic [31:0] dma_adr, dma_dat;
    logic        wb_cyc, wb_stb, wb_we;
    logic [1:0]  wb_sel;
    logic [15:0] wb_adr, wb_dat;
    logic        wb_ack;

    int n_cmp = 0;
    int n_bad = 0;

    wb_dma_arbiter #(
        .NDMA     (NDMA),
        .CPU_SLOT (CPU_SLOT),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cpu_cyc_i  (cpu_cyc),
        .cpu_stb_i  (cpu_stb),
        .cpu_we_i   (cpu_we),
        .cpu_sel_i  (cpu_sel),
        .cpu_adr_i  (cpu_adr),
        .cpu_dat_i  (cpu_dat),
        .cpu_ack_o  (cpu_ack),
        .cpu_gnt_o  (cpu_gnt),
        .dma_req_i  (dma_req),
        .dma_gnt_o  (dma_gnt),
        .dma_cyc_i  (dma_cyc),
        .dma_stb_i  (dma_stb),
        .dma_we_i   (dma_we),
        .dma_sel_i  (dma_sel),
        .dma_adr_i  (dma_adr),
        .dma_dat_i  (dma_dat),
        .dma_ack_o  (dma_ack),
        .wb_cyc_o   (wb_cyc),
        .wb_stb_o   (wb_stb),
        .wb_we_o    (wb_we),
        .wb_sel_o   (wb_sel),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat),
        .wb_ack_i   (wb_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        cpu_cyc = 1'b0; cpu_stb = 1'b0; cpu_we = 1'b0; cpu_sel = '0;
        cpu_adr = '0;   cpu_dat = '0;
        dma_req = '0;   dma_cyc = '0;   dma_stb = '0;  dma_we = '0;
        dma_sel = '0;   dma_adr = '0;   dma_dat = '0;  wb_ack = 1'b0;
    endtask

    // Ends at posedge+1 with reset released and the arbiter idle.
    task automatic do_reset();
        zero_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_grants", {cpu_gnt, dma_gnt}, 3'b100);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- reference model (bus ownership view) ----------------
    int m_owner;     // -1: CPU, else DMA master index (current or incoming)
    bit m_dead;      // 1: dead hand-over cycle before m_owner takes the bus
    int m_last;      // last DMA master granted
    int m_cpu_clk;   // clocks the CPU has owned the bus since it got it back
    int m_tenure;    // clocks into the current DMA tenure

    task automatic model_reset();
        m_owner = -1; m_dead = 1'b0; m_last = NDMA - 1;
        m_cpu_clk = CPU_SLOT; m_tenure = 0;
    endtask

    function automatic logic [42:0] model_out();
        logic cg = 1'b0; logic [1:0] dg = 2'b00; logic ca = 1'b0; logic [1:0] da = 2'b00;
        logic wc = 1'b0; logic ws = 1'b0; logic ww = 1'b0; logic [1:0] sl = 2'b00;
        logic [15:0] ad = 16'h0; logic [15:0] dt = 16'h0; logic w;
        if (!m_dead && m_owner < 0) begin
            cg = 1'b1; ca = wb_ack; wc = cpu_cyc; ws = cpu_stb; ww = cpu_we;
            sl = cpu_sel; ad = cpu_adr; dt = cpu_dat;
        end else if (!m_dead) begin
            w  = (m_owner == 1);
            dg = w ? 2'b10 : 2'b01;
            da = wb_ack ? dg : 2'b00;
            wc = dma_cyc[w]; ws = dma_stb[w]; ww = dma_we[w];
            sl = w ? dma_sel[3:2]   : dma_sel[1:0];
            ad = w ? dma_adr[31:16] : dma_adr[15:0];
            dt = w ? dma_dat[31:16] : dma_dat[15:0];
        end
        return {cg, dg, ca, da, wc, ws, ww, sl, ad, dt};
    endfunction

    task automatic model_step();
        int w;
        int c;
        w = -1;
        if (m_dead) begin
            m_dead = 1'b0;
            if (m_owner >= 0) begin
                m_last = m_owner; m_tenure = 0;
            end else begin
                m_cpu_clk = 0;
            end
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NDMA; k++) begin
                c = (m_last + k) % NDMA;
                if (w < 0 && dma_req[c]) w = c;
            end
            if (w >= 0 && m_cpu_clk >= CPU_SLOT && !cpu_cyc) begin
                m_owner = w; m_dead = 1'b1;
            end
            if (m_cpu_clk < CPU_SLOT) m_cpu_clk++;
        end else begin
            if (!dma_cyc[m_owner] && (!dma_req[m_owner] || m_tenure >= MAX_HOLD)) begin
                m_owner = -1; m_dead = 1'b1;
            end
            m_tenure++;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          n;       // cycles to apply this row
        logic [1:0]  req;
        logic [1:0]  dcyc;
        logic        ccyc;
        logic        ack;
        logic        e_cg;
        logic [1:0]  e_dg;
        logic        e_ca;
        logic [1:0]  e_da;
        logic        e_wc;
        logic [15:0] e_adr;
    } vec_t;

    vec_t tbl [14];

    task automatic run_table();
        tbl[0]  = '{1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 16'h1111};
        tbl[1]  = '{1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 16'h1111};
        tbl[2]  = '{1, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'h0000};
        tbl[3]  = '{1, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01, 1'b1, 16'hAAAA};
        tbl[4]  = '{1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1, 16'hAAAA};
        tbl[5]  = '{1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 16'hAAAA};
        tbl[6]  = '{1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'h0000};
        tbl[7]  = '{1, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 1'b1, 16'h1111};
        tbl[8]  = '{8, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 16'h1111};
        tbl[9]  = '{1, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'h0000};
        tbl[10] = '{1, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b10, 1'b1, 16'hBBBB};
        tbl[11] = '{1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b10, 1'b0, 16'hBBBB};
        tbl[12] = '{1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 16'h0000};
        tbl[13] = '{1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 16'h1111};
        do_reset();
        cpu_adr = 16'h1111;
        dma_adr = 32'hBBBB_AAAA;
        for (int r = 0; r < 14; r++) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                dma_req = tbl[r].req;
                dma_cyc = tbl[r].dcyc;
                cpu_cyc = tbl[r].ccyc;
                wb_ack  = tbl[r].ack;
                #1;
                check($sformatf("vec%0d.%0d", r, c),
                      {cpu_gnt, dma_gnt, cpu_ack, dma_ack, wb_cyc, wb_adr},
                      {tbl[r].e_cg, tbl[r].e_dg, tbl[r].e_ca, tbl[r].e_da, tbl[r].e_wc, tbl[r].e_adr});
                tick();
            end
        end
    endtask

    // ---------------- hand-written sequences ----------------
    task automatic seq_cpu_midcycle();
        do_reset();
        dma_req = 2'b01;
        cpu_cyc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("midcyc_hold%0d", i), {cpu_gnt, dma_gnt}, 3'b100);
        end
        cpu_cyc = 1'b0;
        #1;
        check("midcyc_fall", {cpu_gnt, dma_gnt}, 3'b100);
        tick();
        check("midcyc_hand", {cpu_gnt, dma_gnt}, 3'b000);
        tick();
        check("midcyc_gnt", {cpu_gnt, dma_gnt}, 3'b001);
        dma_req = 2'b00;
        tick();
        check("midcyc_rel", {cpu_gnt, dma_gnt}, 3'b000);
        tick();
        check("midcyc_back", {cpu_gnt, dma_gnt}, 3'b100);
    endtask

    task automatic seq_round_robin();
        logic [1:0] seen [$];
        int gaps [$];
        int ten [2];
        int cpu_run;
        logic [1:0] prev;
        do_reset();
        ten[0] = 0; ten[1] = 0; cpu_run = 0; prev = 2'b00;
        for (int cyc_i = 0; cyc_i < 200 && seen.size() < 3; cyc_i++) begin
            if (cpu_gnt) cpu_run++;
            if (dma_gnt != 2'b00 && prev == 2'b00) begin
                if (seen.size() > 0) gaps.push_back(cpu_run);
                seen.push_back(dma_gnt);
                cpu_run = 0;
            end
            prev = dma_gnt;
            for (int i = 0; i < 2; i++) begin
                if (dma_gnt[i]) begin
                    ten[i]++;
                    dma_req[i] = (ten[i] < 4);
                    dma_cyc[i] = (ten[i] < 4);
                end else begin
                    ten[i] = 0;
                    dma_req[i] = 1'b1;
                    dma_cyc[i] = 1'b0;
                end
            end
            tick();
        end
        check("rr_tenures", seen.size(), 3);
        if (seen.size() == 3) begin
            check("rr_grant0", seen[0], 2'b01);
            check("rr_grant1", seen[1], 2'b10);
            check("rr_grant2", seen[2], 2'b01);
            check("rr_cpu_window0", gaps[0], CPU_SLOT + 1);
            check("rr_cpu_window1", gaps[1], CPU_SLOT + 1);
        end
    endtask

    task automatic seq_hold_limit();
        int t;
        do_reset();
        dma_req = 2'b01;
        for (int w = 0; w < 10 && !dma_gnt[0]; w++) tick();
        check("hold_grant", dma_gnt, 2'b01);
        t = 0;
        for (int k = 0; k < 60; k++) begin
            if (!dma_gnt[0]) break;
            dma_cyc[0] = ((t % 4) != 3);
            t++;
            tick();
        end
        check("hold_len", t, MAX_HOLD + 4);
        check("hold_ret", {cpu_gnt, dma_gnt}, 3'b000);
        tick();
        check("hold_cpu", {cpu_gnt, dma_gnt}, 3'b100);
    endtask

    task automatic seq_reset_mid_tenure();
        do_reset();
        dma_req = 2'b01;
        dma_cyc = 2'b01;
        tick();
        tick();
        check("rst_pre_gnt", {cpu_gnt, dma_gnt}, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {cpu_gnt, dma_gnt}, 3'b100);
        dma_req = 2'b10;
        dma_cyc = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_hand", {cpu_gnt, dma_gnt}, 3'b000);
        tick();
        check("rst_m1_gnt", {cpu_gnt, dma_gnt}, 3'b010);
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic run_random();
        do_reset();
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(7) == 0) dma_req[b] = ~dma_req[b];
            end
            dma_cyc = 2'($urandom);
            dma_stb = 2'($urandom);
            dma_we  = 2'($urandom);
            dma_sel = 4'($urandom);
            dma_adr = $urandom;
            dma_dat = $urandom;
            cpu_cyc = ($urandom_range(3) == 0);
            cpu_stb = 1'($urandom);
            cpu_we  = 1'($urandom);
            cpu_sel = 2'($urandom);
            cpu_adr = 16'($urandom);
            cpu_dat = 16'($urandom);
            wb_ack  = 1'($urandom);
            #1;
            check($sformatf("rand%0d", i),
                  {cpu_gnt, dma_gnt, cpu_ack, dma_ack, wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat},
                  model_out());
            check($sformatf("onehot%0d", i), ($countones({cpu_gnt, dma_gnt}) <= 1), 1'b1);
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    initial begin
        zero_inputs();
        run_table();
        seq_cpu_midcycle();
        seq_round_robin();
        seq_hold_limit();
        seq_reset_mid_tenure();
        run_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, want finish before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule
